asic_cfg_sequencer: RTL

Controller that programs the analog ASIC configuration chain (DYNCNF + STATCNF) over the serial CLK/SEL/MOSI/MISO link. It replaces the fixed-pattern clock-gating switches with a request-driven engine. It serialises a captured configuration frame at a programmable serial rate, then re-shifts the frame to read back the previous chain contents on MISO. It compares the readback, retries on mismatch and reports pass/fail. It sits between the system control logic and the bridge output pins.

---
 rtl/asic_cfg_pkg.sv | 24 ++
 rtl/asic_cfg_sequencer_engine.sv | 85 ++++++++
 rtl/asic_cfg_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/asic_cfg_pkg.sv
// Shared types and constants for the ASIC configuration-chain sequencer.
// FRAME_LEN is the full chain length: dynamic register followed by static register.
package asic_cfg_pkg;

    localparam int SIZESRSTAT_DEF = 88;
    localparam int SIZESRDYN_DEF  = 16;
    localparam int FRAME_LEN      = SIZESRDYN_DEF + SIZESRSTAT_DEF;
    localparam int RETRY_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SHIFT,
        ST_LATCH,
        ST_RB_SHIFT,
        ST_COMPARE,
        ST_RETRY_GAP
    } cfg_state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/asic_cfg_sequencer_engine.sv
// Serial shift engine for the configuration chain.
// On go it loads a frame and shifts it out MSB first, one bit per CLK_DIV clocks.
// Each bit: mosi changes at bit start, sclk is low for the first half and high for
// the second half, and miso is captured on the edge where sclk rises.
// bit_done marks the final clock of each bit; last_bit marks the final bit of the frame.
module cfg_shift_engine
    import asic_cfg_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_LEN,
    parameter int CLK_DIV    = 8
) (
    input  logic                  clk,
    input  logic                  srst,
    input  logic                  go,
    input  logic [FRAME_BITS-1:0] load_word,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  bit_done,
    output logic                  last_bit,
    output logic [FRAME_BITS-1:0] rb_word
);

    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int BIT_W = cnt_width(FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

    logic [FRAME_BITS-1:0] shift_reg;
    logic [FRAME_BITS-1:0] rb_reg;
    logic [DIV_W-1:0]      div_reg;
    logic [BIT_W-1:0]      bit_reg;
    logic                  active_reg;
    logic                  sclk_reg;
    logic                  mosi_reg;

    assign bit_done = active_reg && (div_reg == DIV_LAST);
    assign last_bit = (bit_reg == BIT_LAST);
    assign sclk     = sclk_reg;
    assign mosi     = mosi_reg;
    assign rb_word  = rb_reg;

    // Divider, bit sequencing, sclk/mosi generation and miso capture.
    always_ff @(posedge clk) begin
        if (srst) begin
            shift_reg  <= '0;
            rb_reg     <= '0;
            div_reg    <= '0;
            bit_reg    <= '0;
            active_reg <= 1'b0;
            sclk_reg   <= 1'b0;
            mosi_reg   <= 1'b0;
        end else if (go) begin
            shift_reg  <= {load_word[FRAME_BITS-2:0], 1'b0};
            mosi_reg   <= load_word[FRAME_BITS-1];
            sclk_reg   <= 1'b0;
            div_reg    <= '0;
            bit_reg    <= '0;
            active_reg <= 1'b1;
        end else if (active_reg) begin
            // Rising sclk: the chain output is stable, take it into the readback word.
            if (div_reg == DIV_HALF) begin
                sclk_reg <= 1'b1;
                rb_reg   <= {rb_reg[FRAME_BITS-2:0], miso};
            end
            if (bit_done) begin
                sclk_reg <= 1'b0;
                div_reg  <= '0;
                if (last_bit) begin
                    // Frame finished: park the line low so mosi never leads sel.
                    active_reg <= 1'b0;
                    mosi_reg   <= 1'b0;
                end else begin
                    bit_reg   <= bit_reg + 1'b1;
                    mosi_reg  <= shift_reg[FRAME_BITS-1];
                    shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                end
            end else begin
                div_reg <= div_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/asic_cfg_sequencer.sv
// Request-driven programmer for the analog ASIC DYNCNF+STATCNF chain.
// A start captures {dyn, stat}, shifts it out, drops sel to latch it, then (with
// ASIC_CFG_READBACK_EN defined) re-shifts the same frame to read the previous chain
// contents back, compares, and retries up to MAX_RETRY times before flagging err_o.
// Without ASIC_CFG_READBACK_EN the sequence ends after the latch gap; miso_i is
// ignored and err_o / retry_cnt_o stay 0.
module asic_cfg_sequencer
    import asic_cfg_pkg::*;
#(
    parameter int SIZESRSTAT = SIZESRSTAT_DEF,
    parameter int SIZESRDYN  = SIZESRDYN_DEF,
    parameter int CLK_DIV    = 8,
    parameter int MAX_RETRY  = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start_i,
    input  logic [SIZESRDYN-1:0]  dyn_cfg_i,
    input  logic [SIZESRSTAT-1:0] stat_cfg_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [RETRY_W-1:0]    retry_cnt_o,
    output logic                  sclk_o,
    output logic                  sel_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    localparam int FRAME_W = SIZESRDYN + SIZESRSTAT;
    localparam int DIV_W   = cnt_width(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    cfg_state_t           state_reg;
    logic [FRAME_W-1:0]   frame_reg;
    logic [DIV_W-1:0]     gap_reg;
    logic                 busy_reg;
    logic                 done_reg;
    logic                 sel_reg;

    logic                 accept;
    logic                 gap_last;
    logic                 frame_end;
    logic                 eng_go;
    logic [FRAME_W-1:0]   eng_load;
    logic                 eng_bit_done;
    logic                 eng_last_bit;
    logic [FRAME_W-1:0]   rb_word;

    // A request is taken only in IDLE and never in the cycle that shows done_o.
    assign accept    = (state_reg == ST_IDLE) && start_i && !done_reg;
    assign gap_last  = (gap_reg == DIV_LAST);
    assign frame_end = eng_bit_done && eng_last_bit;

    // Engine kick: load straight from the inputs on accept so the first bit is on
    // the wire one edge after the request; later passes reuse the captured frame.
    always_comb begin
        eng_go   = 1'b0;
        eng_load = frame_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    eng_go   = 1'b1;
                    eng_load = {dyn_cfg_i, stat_cfg_i};
                end
            end
`ifdef ASIC_CFG_READBACK_EN
            ST_LATCH:     eng_go = gap_last;
            ST_RETRY_GAP: eng_go = gap_last;
`endif
            default: ;
        endcase
    end

    cfg_shift_engine #(
        .FRAME_BITS (FRAME_W),
        .CLK_DIV    (CLK_DIV)
    ) u_engine (
        .clk       (CLK),
        .srst      (RST),
        .go        (eng_go),
        .load_word (eng_load),
        .miso      (miso_i),
        .sclk      (sclk_o),
        .mosi      (mosi_o),
        .bit_done  (eng_bit_done),
        .last_bit  (eng_last_bit),
        .rb_word   (rb_word)
    );

`ifdef ASIC_CFG_READBACK_EN
    logic                 err_reg;
    logic [RETRY_W-1:0]   retry_reg;

    assign err_o       = err_reg;
    assign retry_cnt_o = retry_reg;
`else
    logic unused_rb;

    assign unused_rb   = ^{rb_word, RETRY_W'(MAX_RETRY)};
    assign err_o       = 1'b0;
    assign retry_cnt_o = '0;
`endif

    assign busy_o = busy_reg;
    assign done_o = done_reg;
    assign sel_o  = sel_reg;

    // Sequencer FSM: owns sel, the latch/retry gaps, retry accounting and status.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg <= ST_IDLE;
            frame_reg <= '0;
            gap_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sel_reg   <= 1'b0;
`ifdef ASIC_CFG_READBACK_EN
            err_reg   <= 1'b0;
            retry_reg <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        frame_reg <= {dyn_cfg_i, stat_cfg_i};
                        busy_reg  <= 1'b1;
                        sel_reg   <= 1'b1;
                        state_reg <= ST_WR_SHIFT;
`ifdef ASIC_CFG_READBACK_EN
                        err_reg   <= 1'b0;
                        retry_reg <= '0;
`endif
                    end
                end
                ST_WR_SHIFT: begin
                    if (frame_end) begin
                        sel_reg   <= 1'b0;
                        gap_reg   <= '0;
                        state_reg <= ST_LATCH;
                    end
                end
                ST_LATCH: begin
                    if (gap_last) begin
`ifdef ASIC_CFG_READBACK_EN
                        sel_reg   <= 1'b1;
                        state_reg <= ST_RB_SHIFT;
`else
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
`endif
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
`ifdef ASIC_CFG_READBACK_EN
                ST_RB_SHIFT: begin
                    if (frame_end) begin
                        sel_reg   <= 1'b0;
                        state_reg <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    if (rb_word == frame_reg) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end else if (retry_reg < RETRY_W'(MAX_RETRY)) begin
                        retry_reg <= retry_reg + 1'b1;
                        gap_reg   <= '0;
                        state_reg <= ST_RETRY_GAP;
                    end else begin
                        err_reg   <= 1'b1;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= ST_IDLE;
                    end
                end
                ST_RETRY_GAP: begin
                    if (gap_last) begin
                        sel_reg   <= 1'b1;
                        state_reg <= ST_WR_SHIFT;
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
`endif
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
